accumulator: RTL and testbench
==============================

ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data width of in and out.
REQ-002 Port clk SHALL be an input, 1 bit wide, and SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit wide, acting as the asynchronous, active-low reset.
REQ-004 Port in SHALL be an input, WIDTH bits wide, unsigned addend sampled every rising clk edge.
REQ-005 Port out SHALL be an output, WIDTH bits wide, registered accumulator value.
REQ-006 Port carry SHALL be an output, 1 bit wide, registered; it is 1 when the most recent accumulate wrapped.
REQ-007 Port ovf SHALL be an output, 1 bit wide, registered sticky flag; it is 1 if any accumulate has wrapped since reset.
REQ-008 The positional port order SHALL be in, out, clk, reset, carry, ovf, so that a 4-port positional instantiation (in, out, clk, reset) connects correctly with carry and ovf left open.

Function
REQ-009 On each rising clk edge with reset high, out SHALL load (out + in) mod 2^WIDTH.
REQ-010 Accumulation SHALL run every cycle with no enable; an input of 0 holds the value.
REQ-011 Latency SHALL be one cycle: the in value sampled at edge N appears in out immediately after edge N.
REQ-012 Arithmetic SHALL be unsigned with wrap-around; no saturation.
REQ-013 carry SHALL be loaded on the same edge with the carry-out bit of the WIDTH-bit addition (bit WIDTH of out + in).
REQ-014 ovf SHALL load (ovf OR that carry-out) on each edge; once set, it clears only through reset.
REQ-015 An X or Z on in SHALL NOT be masked; the behaviour of out under such input is unspecified.
REQ-016 There SHALL be no combinational path from in to out, carry or ovf.

Reset
REQ-017 While reset is low, out, carry and ovf SHALL be 0, asynchronously, regardless of clk.
REQ-018 Reset assertion mid-operation SHALL clear all state immediately, without waiting for a clock edge.
REQ-019 On reset release, the first rising clk edge with reset high SHALL perform a normal accumulate starting from 0.
REQ-020 A clk edge coincident with the reset falling edge SHALL leave all outputs at 0.
REQ-021 Before the first reset assertion, output values SHALL be undefined; the bench applies reset before checking outputs.

Verification
REQ-022 Drive in=1 and reset low from t=5 ns, with a 10 ns clk period, for 50 ns -> out=0, carry=0 and ovf=0 throughout the reset period.
REQ-023 After reset, release reset with in=1 for 5 edges -> out=1,2,3,4,5 on successive edges; carry=0 and ovf=0.
REQ-024 After reset, apply in=16'hFFFF for one edge, then in=16'h0002 for one edge -> out=16'hFFFF with carry=0, then out=16'h0001 with carry=1 and ovf=1.
REQ-025 Continuing REQ-024, apply in=0 for 3 edges -> out holds 16'h0001, carry=0, ovf stays 1.
REQ-026 With out=16'h1234, pull reset low between clock edges -> out, carry and ovf read 0 immediately (before the next edge).
REQ-027 Set parameter WIDTH=8 and apply in=8'h80 twice -> out=8'h80, then 8'h00 with carry=1 and ovf=1.

Source files
------------

// File: rtl/accumulator_if.sv
// Signal bundle for the accumulator data path: addend in, running sum and wrap flags out.
// The testbench groups its stimulus and observation signals through this interface.
interface accumulator_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic             carry;
    logic             ovf;

    modport master (
        output in,
        input  out,
        input  carry,
        input  ovf
    );

    modport slave (
        input  in,
        output out,
        output carry,
        output ovf
    );
endinterface

// File: rtl/accumulator.sv
// Free-running unsigned wrap-around accumulator with per-cycle carry and sticky overflow.
// Plain ports in fixed positional order so legacy 4-port instantiations (in, out, clk, reset) still bind.
module accumulator #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    input  logic             clk,
    input  logic             reset,
    output logic             carry,
    output logic             ovf
);
    logic [WIDTH:0] sum;

    // One extra bit catches the carry-out of the WIDTH-bit add.
    assign sum = {1'b0, out} + {1'b0, in};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            out   <= sum[WIDTH-1:0];
            carry <= sum[WIDTH];
            ovf   <= ovf | sum[WIDTH];
        end
    end
endmodule

// File: tb/tb_accumulator.sv
// Self-checking bench for accumulator: reset behaviour, directed vector table,
// randomized run against an arithmetic reference model, async reset and WIDTH=8 corner.
module tb_accumulator;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    accumulator_if #(.WIDTH(16)) if16 ();
    accumulator_if #(.WIDTH(8))  if8  ();

    accumulator #(.WIDTH(16)) dut16 (
        .in    (if16.in),
        .out   (if16.out),
        .clk   (clk),
        .reset (reset),
        .carry (if16.carry),
        .ovf   (if16.ovf)
    );

    accumulator #(.WIDTH(8)) dut8 (
        .in    (if8.in),
        .out   (if8.out),
        .clk   (clk),
        .reset (reset),
        .carry (if8.carry),
        .ovf   (if8.ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          do_reset;
        logic [15:0] in;
        logic [15:0] exp_out;
        logic        exp_carry;
        logic        exp_ovf;
    } vec_t;

    // reference model state
    longint m_out;
    bit     m_carry;
    bit     m_ovf;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input longint eo, input longint ec, input longint ev);
        check({name, ".out"},   longint'(if16.out),   eo);
        check({name, ".carry"}, longint'(if16.carry), ec);
        check({name, ".ovf"},   longint'(if16.ovf),   ev);
    endtask

    // Called at a falling edge; returns at a falling edge with state cleared.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        check16("reset_async", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        m_out = 0; m_carry = 0; m_ovf = 0;
    endtask

    task automatic model_step(input longint addend, input int width);
        longint s;
        longint modulus;
        modulus = longint'(1) << width;
        s       = m_out + addend;
        m_carry = (s >= modulus);
        m_out   = s % modulus;
        m_ovf   = m_ovf | m_carry;
    endtask

    vec_t vecs[$];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        if16.in  = 16'd1;
        if8.in   = 8'd0;

        // reset asserted at t=5, coincident with a rising edge
        #5 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check16("in_reset", 0, 0, 0);
        end
        @(negedge clk);
        reset = 1'b1;

        vecs.push_back('{0, 16'h0001, 16'h0001, 1'b0, 1'b0});
        vecs.push_back('{0, 16'h0001, 16'h0002, 1'b0, 1'b0});
        vecs.push_back('{0, 16'h0001, 16'h0003, 1'b0, 1'b0});
        vecs.push_back('{0, 16'h0001, 16'h0004, 1'b0, 1'b0});
        vecs.push_back('{0, 16'h0001, 16'h0005, 1'b0, 1'b0});
        vecs.push_back('{1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0});
        vecs.push_back('{0, 16'h0002, 16'h0001, 1'b1, 1'b1});
        vecs.push_back('{0, 16'h0000, 16'h0001, 1'b0, 1'b1});
        vecs.push_back('{0, 16'h0000, 16'h0001, 1'b0, 1'b1});
        vecs.push_back('{0, 16'h0000, 16'h0001, 1'b0, 1'b1});
        vecs.push_back('{0, 16'hFFFF, 16'h0000, 1'b1, 1'b1});
        vecs.push_back('{0, 16'h8000, 16'h8000, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].do_reset) do_reset();
            if16.in = vecs[i].in;
            @(posedge clk);
            @(negedge clk);
            check16($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_carry, vecs[i].exp_ovf);
        end

        // randomized run against the arithmetic model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            longint v;
            case ($urandom_range(0, 3))
                0:       v = 0;
                1:       v = longint'($urandom_range(16'hF000, 16'hFFFF));
                default: v = longint'($urandom_range(0, 16'hFFFF));
            endcase
            if (i == 150) do_reset();
            if16.in = 16'(v);
            #1;
            check("no_comb_path", longint'(if16.out), m_out);
            @(posedge clk);
            @(negedge clk);
            model_step(v, 16);
            check16($sformatf("rand%0d", i), m_out, m_carry, m_ovf);
        end

        // async reset between edges with a live value
        do_reset();
        if16.in = 16'h1234;
        @(posedge clk);
        @(negedge clk);
        check16("pre_async", 16'h1234, 0, 0);
        if16.in = 16'h0000;
        #2 reset = 1'b0;
        #1 check16("async_clear", 0, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check16("after_release", 0, 0, 0);

        // WIDTH=8 wrap
        do_reset();
        if8.in = 8'h80;
        @(posedge clk);
        @(negedge clk);
        check("w8_first.out",   longint'(if8.out),   8'h80);
        check("w8_first.carry", longint'(if8.carry), 0);
        check("w8_first.ovf",   longint'(if8.ovf),   0);
        @(posedge clk);
        @(negedge clk);
        check("w8_wrap.out",   longint'(if8.out),   8'h00);
        check("w8_wrap.carry", longint'(if8.carry), 1);
        check("w8_wrap.ovf",   longint'(if8.ovf),   1);
        if8.in = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("w8_hold.carry", longint'(if8.carry), 0);
        check("w8_hold.ovf",   longint'(if8.ovf),   1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
